// File: rtl/tri_dispatch.sv
// Triangle dispatcher: queues 144-bit triangle words, serialises each MSB-first on a
// frame-start pulse, then waits for the rasterizer to finish under a watchdog.
module tri_dispatch #(
   parameter int unsigned DEPTH   = 2,
   parameter logic [19:0] TIMEOUT = 20'd400000,
   localparam int unsigned LW     = $clog2(DEPTH + 1)
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic [143:0]  TRI_DATA,
   input  logic          TRI_VALID,
   output logic          TRI_READY,
   input  logic          FRAME_START,
   input  logic          RAST_DONE,
   output logic          SD,
   output logic          SD_VALID,
   output logic          BUSY,
   output logic [LW-1:0] FIFO_LEVEL,
   output logic [15:0]   TRI_COUNT,
   output logic          ERR
);

   localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StWaitSync, StShift, StWaitDone} state_e;

   state_e         state_q, state_d;
   logic [143:0]   fifo_q [DEPTH];
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]  level_q, level_d;
   logic [143:0]   shift_q, shift_d;
   logic [7:0]     bit_cnt_q, bit_cnt_d;
   logic           sd_q, sd_d, sd_valid_q, sd_valid_d;
   logic [19:0]    wd_q, wd_d;
   logic [15:0]    count_q, count_d;
   logic           err_q, err_d;
   logic           push, pop;
   logic [143:0]   head;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   // Ready is held low in reset so nothing offered then is ever captured.
   assign TRI_READY = RST_N && (level_q < FULL);
   assign push      = TRI_VALID && TRI_READY;
   assign head      = fifo_q[rd_ptr_q];

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      sd_d       = 1'b0;
      sd_valid_d = 1'b0;
      wd_d       = wd_q;
      count_d    = count_q;
      err_d      = err_q;
      pop        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (level_q != '0) state_d = StWaitSync;
         end
         StWaitSync: begin
            if (FRAME_START) begin
               pop        = 1'b1;
               sd_d       = head[143];
               sd_valid_d = 1'b1;
               shift_d    = {head[142:0], 1'b0};
               bit_cnt_d  = 8'd1;
               state_d    = StShift;
            end
         end
         StShift: begin
            if (bit_cnt_q == 8'd144) begin
               wd_d    = '0;
               state_d = StWaitDone;
            end else begin
               sd_d       = shift_q[143];
               sd_valid_d = 1'b1;
               shift_d    = {shift_q[142:0], 1'b0};
               bit_cnt_d  = bit_cnt_q + 8'd1;
            end
         end
         StWaitDone: begin
            wd_d = wd_q + 20'd1;
            // A done pulse on the timeout cycle still counts as success.
            if (RAST_DONE || (wd_d == TIMEOUT)) begin
               if (RAST_DONE) count_d = count_q + 16'd1;
               else           err_d   = 1'b1;
               state_d = ((level_q != '0) || push) ? StWaitSync : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      level_d  = level_q + LW'(push) - LW'(pop);
   end

   always_ff @(posedge CLK) begin
      if (push) fifo_q[wr_ptr_q] <= TRI_DATA;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         sd_q       <= 1'b0;
         sd_valid_q <= 1'b0;
         wd_q       <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         sd_q       <= sd_d;
         sd_valid_q <= sd_valid_d;
         wd_q       <= wd_d;
         count_q    <= count_d;
         err_q      <= err_d;
      end
   end

   assign SD         = sd_q;
   assign SD_VALID   = sd_valid_q;
   assign BUSY       = (state_q != StIdle);
   assign FIFO_LEVEL = level_q;
   assign TRI_COUNT  = count_q;
   assign ERR        = err_q;

endmodule

// File: tb/tb_tri_dispatch.sv
// Bench for tri_dispatch: two instances (short and default watchdog) share stimulus and are
// checked every cycle against a queue-based model, plus hand-computed literal checks.
module tb_tri_dispatch;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [143:0] tri_data = '0;
   logic         tri_valid = 1'b0;
   logic         frame_start = 1'b0;
   logic         rast_done = 1'b0;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   localparam logic [143:0] TRI_T = 144'h0040_0080_00C0_0040_0100_0040_F800_07E0_001F;
   localparam logic [143:0] TRI_A = 144'hA5A5_1234_5678_9ABC_DEF0_0F0F_F0F0_3C3C_C3C3;
   localparam logic [143:0] TRI_B = 144'h5A5A_0001_0002_0003_0004_0005_0006_0007_0008;
   localparam logic [143:0] TRI_C = 144'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
   localparam logic [143:0] TRI_D = 144'h8000_0000_0000_0000_0000_0000_0000_0000_0001;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_i
      localparam logic [19:0] TO = (g == 0) ? 20'd100 : 20'd400000;
      logic        ready, sd, sdv, busy, err;
      logic [1:0]  lvl;
      logic [15:0] cnt;
      logic [22:0] act, expv;

      tri_dispatch #(.DEPTH(2), .TIMEOUT(TO)) u_dut (
         .CLK         (clk),
         .RST_N       (rst_n),
         .TRI_DATA    (tri_data),
         .TRI_VALID   (tri_valid),
         .TRI_READY   (ready),
         .FRAME_START (frame_start),
         .RAST_DONE   (rast_done),
         .SD          (sd),
         .SD_VALID    (sdv),
         .BUSY        (busy),
         .FIFO_LEVEL  (lvl),
         .TRI_COUNT   (cnt),
         .ERR         (err)
      );

      // Model: a queue of pending words, a queue of bits still to appear on SD, a phase.
      logic [143:0] q [$];
      logic         bits [$];
      int           phase = 0;
      int           wd = 0;
      int           m_size = 0;
      logic         m_sd = 1'b0, m_sdv = 1'b0, m_err = 1'b0;
      logic [15:0]  m_cnt = '0;

      always @(posedge clk) begin
         logic         push_m;
         int           nsize;
         logic [143:0] w;
         if (!rst_n) begin
            q.delete();
            bits.delete();
            phase = 0; wd = 0; m_cnt = '0; m_err = 1'b0; m_sd = 1'b0; m_sdv = 1'b0;
         end else begin
            push_m = tri_valid && (q.size() < 2);
            nsize  = q.size() + (push_m ? 1 : 0);
            case (phase)
               0: if (q.size() > 0) phase = 1;
               1: if (frame_start) begin
                     w = q.pop_front();
                     for (int i = 143; i >= 0; i--) bits.push_back(w[i]);
                     phase = 2;
                  end
               2: if (bits.size() == 0) begin phase = 3; wd = 0; end
               default: begin
                  wd = wd + 1;
                  if (rast_done) begin
                     m_cnt = m_cnt + 16'd1;
                     phase = (nsize > 0) ? 1 : 0;
                  end else if (wd == int'(TO)) begin
                     m_err = 1'b1;
                     phase = (nsize > 0) ? 1 : 0;
                  end
               end
            endcase
            if (bits.size() > 0) begin m_sd = bits.pop_front(); m_sdv = 1'b1; end
            else begin m_sd = 1'b0; m_sdv = 1'b0; end
            if (push_m) q.push_back(tri_data);
         end
         m_size = q.size();
      end

      assign act  = {ready, sd, sdv, busy, lvl, cnt, err};
      assign expv = {rst_n && (m_size < 2), m_sd, m_sdv, (phase != 0), m_size[1:0], m_cnt, m_err};
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
      end
   endtask

   task automatic chk_word(input string name, input logic [143:0] got, input logic [143:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // Per-cycle comparison of every output of both instances against the model.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      n_total++;
      if (g_i[0].act !== g_i[0].expv) begin
         n_bad++;
         $display("FAIL outputs_inst0 cyc=%0d got=%h want=%h", cyc, g_i[0].act, g_i[0].expv);
      end
      n_total++;
      if (g_i[1].act !== g_i[1].expv) begin
         n_bad++;
         $display("FAIL outputs_inst1 cyc=%0d got=%h want=%h", cyc, g_i[1].act, g_i[1].expv);
      end
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      logic [143:0] word;
      int           nvalid;

      // Reset with a push offered: must be discarded.
      tri_valid = 1'b1;
      tri_data  = TRI_C;
      steps(3);
      chk("ready_in_reset", 32'(g_i[0].ready), 32'd0);
      tri_valid = 1'b0;
      rst_n     = 1'b1;
      step();
      chk("reset_level", 32'(g_i[0].lvl), 32'd0);
      chk("reset_busy", 32'(g_i[0].busy), 32'd0);
      chk("reset_count", 32'(g_i[0].cnt), 32'd0);
      chk("reset_sdv", 32'(g_i[0].sdv), 32'd0);

      // Single triangle, FRAME_START three cycles after the push.
      tri_data  = TRI_T;
      tri_valid = 1'b1;
      step();
      tri_valid = 1'b0;
      chk("one_push_level", 32'(g_i[1].lvl), 32'd1);
      steps(2);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      word = '0;
      nvalid = 0;
      for (int i = 0; i < 144; i++) begin
         word[143-i] = g_i[1].sd;
         nvalid += int'(g_i[1].sdv);
         step();
      end
      chk_word("stream_T", word, TRI_T);
      chk("stream_T_valid_cycles", 32'(nvalid), 32'd144);
      chk("sdv_after_frame", 32'(g_i[1].sdv), 32'd0);
      steps(99);
      chk("wd_cycle100_no_err_yet", 32'(g_i[0].err), 32'd0);
      step();
      chk("timeout_err_set", 32'(g_i[0].err), 32'd1);
      chk("timeout_count_same", 32'(g_i[0].cnt), 32'd0);
      chk("timeout_to_idle", 32'(g_i[0].busy), 32'd0);
      steps(255);
      rast_done = 1'b1;
      step();
      rast_done = 1'b0;
      chk("done_count", 32'(g_i[1].cnt), 32'd1);
      chk("done_busy", 32'(g_i[1].busy), 32'd0);
      chk("done_no_err", 32'(g_i[1].err), 32'd0);
      chk("late_done_ignored", 32'(g_i[0].cnt), 32'd0);

      // Only reset clears ERR.
      rst_n = 1'b0;
      step();
      chk("reset_clears_err", 32'(g_i[0].err), 32'd0);
      chk("reset_clears_count", 32'(g_i[1].cnt), 32'd0);
      rst_n = 1'b1;
      step();

      // Three back-to-back pushes into a depth-2 FIFO.
      tri_valid = 1'b1;
      tri_data  = TRI_A;
      chk("ready_push1", 32'(g_i[0].ready), 32'd1);
      step();
      tri_data = TRI_B;
      chk("ready_push2", 32'(g_i[0].ready), 32'd1);
      step();
      tri_data = TRI_C;
      chk("ready_push3_full", 32'(g_i[0].ready), 32'd0);
      step();
      tri_valid = 1'b0;
      steps(2);
      chk("full_level", 32'(g_i[0].lvl), 32'd2);

      // Stray FRAME_START / RAST_DONE during SHIFT, including on the last bit.
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      word = '0;
      for (int i = 0; i < 144; i++) begin
         word[143-i] = g_i[1].sd;
         frame_start = (i == 10) || (i == 50) || (i == 143);
         rast_done   = (i == 30) || (i == 143);
         step();
      end
      frame_start = 1'b0;
      rast_done   = 1'b0;
      chk_word("stream_A_with_noise", word, TRI_A);
      chk("noise_count_same", 32'(g_i[1].cnt), 32'd0);
      chk("noise_level", 32'(g_i[1].lvl), 32'd1);
      steps(99);
      rast_done = 1'b1;
      step();
      rast_done = 1'b0;
      chk("done_on_timeout_no_err", 32'(g_i[0].err), 32'd0);
      chk("done_on_timeout_counts", 32'(g_i[0].cnt), 32'd1);
      chk("next_queued_busy", 32'(g_i[0].busy), 32'd1);

      // Timeout with a triangle queued behind: next FRAME_START dispatches it.
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      tri_valid = 1'b1;
      tri_data  = TRI_D;
      step();
      tri_valid = 1'b0;
      steps(143);
      steps(99);
      chk("b_wd_cycle100_no_err", 32'(g_i[0].err), 32'd0);
      step();
      chk("b_timeout_err", 32'(g_i[0].err), 32'd1);
      chk("b_timeout_count", 32'(g_i[0].cnt), 32'd1);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("d_dispatched_sdv", 32'(g_i[0].sdv), 32'd1);
      chk("d_first_bit", 32'(g_i[0].sd), 32'd1);
      chk("waitdone_ignores_fs", 32'(g_i[1].sdv), 32'd0);
      chk("waitdone_keeps_queue", 32'(g_i[1].lvl), 32'd1);

      // Reset at SHIFT bit 70 aborts the frame.
      steps(69);
      chk("bit70_still_valid", 32'(g_i[0].sdv), 32'd1);
      rst_n = 1'b0;
      step();
      chk("abort_sdv", 32'(g_i[0].sdv), 32'd0);
      chk("abort_level", 32'(g_i[0].lvl), 32'd0);
      chk("abort_count", 32'(g_i[0].cnt), 32'd0);
      chk("abort_err", 32'(g_i[0].err), 32'd0);
      chk("abort_level_inst1", 32'(g_i[1].lvl), 32'd0);
      rst_n = 1'b1;
      steps(3);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/tri_dispatch.md
TRI_DISPATCH -- requirements
Module: tri_dispatch

Interface
REQ-001 Parameter DEPTH, default 2: triangle FIFO depth in entries (1..4).
REQ-002 Parameter TIMEOUT, default 20'd400000: maximum WAIT_DONE cycles before abort.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RST_N  in  1  synchronous, active-low reset.
REQ-005 TRI_DATA  in  144  triangle word: [143:128]=v0x, [127:112]=v1x, [111:96]=v2x, [95:80]=v0y, [79:64]=v1y, [63:48]=v2y, [47:32]=c0, [31:16]=c1, [15:0]=c2; all Q10.6.
REQ-006 TRI_VALID  in  1  host offers TRI_DATA.
REQ-007 TRI_READY  out  1  block can accept a triangle this cycle.
REQ-008 FRAME_START  in  1  one-cycle pulse, one cycle before the rasterizer's 144-cycle input frame begins.
REQ-009 RAST_DONE  in  1  rasterizer DONE pulse: current triangle finished.
REQ-010 SD  out  1  serial triangle data to the rasterizer D input.
REQ-011 SD_VALID  out  1  high exactly while SD carries a frame bit.
REQ-012 BUSY  out  1  high whenever state is not IDLE.
REQ-013 FIFO_LEVEL  out  clog2(DEPTH+1)  entries currently queued.
REQ-014 TRI_COUNT  out  16  triangles completed since reset; wraps at 65535 to 0.
REQ-015 ERR  out  1  sticky watchdog-timeout flag.

Function
REQ-016 The push SHALL occur on any cycle with TRI_VALID=1 and TRI_READY=1; TRI_READY SHALL be (FIFO_LEVEL<DEPTH), derived from registered level only, never from TRI_VALID.
REQ-017 The FIFO SHALL be first-in first-out; a pop and push in the same cycle SHALL leave FIFO_LEVEL unchanged; a full FIFO SHALL refuse a push even in a pop cycle.
REQ-018 The FSM SHALL have exactly the states IDLE, WAIT_SYNC, SHIFT, WAIT_DONE.
REQ-019 IDLE -> WAIT_SYNC SHALL occur on the first cycle FIFO_LEVEL>0.
REQ-020 In WAIT_SYNC, when FRAME_START=1, the head entry SHALL be loaded into a 144-bit shift register, popped, and the FSM SHALL enter SHIFT.
REQ-021 With FRAME_START high in cycle t, SD SHALL carry TRI_DATA bit 143 in cycle t+1, descending one bit per cycle, to bit 0 in cycle t+144 (registered output).
REQ-022 SD_VALID SHALL be 1 in cycles t+1..t+144 only; SD SHALL be 0 whenever SD_VALID=0.
REQ-023 After the 144th bit the FSM SHALL enter WAIT_DONE and clear the watchdog counter.
REQ-024 FRAME_START outside WAIT_SYNC SHALL be ignored.
REQ-025 RAST_DONE outside WAIT_DONE SHALL be ignored, including a pulse coincident with the last SHIFT bit.
REQ-026 In WAIT_DONE, RAST_DONE=1 SHALL increment TRI_COUNT and move the FSM to WAIT_SYNC if FIFO_LEVEL>0 after any same-cycle push, else to IDLE.
REQ-027 In WAIT_DONE, the watchdog SHALL increment each cycle; on reaching TIMEOUT without RAST_DONE, ERR SHALL be set, TRI_COUNT SHALL remain unchanged, and the FSM SHALL take the REQ-026 next-state rule.
REQ-028 RAST_DONE in the same cycle the watchdog reaches TIMEOUT SHALL count as success (no ERR).
REQ-029 ERR SHALL be cleared only by reset.

Reset
REQ-030 With RST_N=0 at a rising edge: state=IDLE, FIFO emptied, FIFO_LEVEL=0, shift register=0, SD=0, SD_VALID=0, BUSY=0, TRI_COUNT=0, ERR=0, watchdog=0.
REQ-031 TRI_READY SHALL be 0 while RST_N=0; pushes presented during reset SHALL be discarded.
REQ-032 Reset mid-SHIFT or mid-WAIT_DONE SHALL abort the frame immediately, SD/SD_VALID 0 from the next cycle, with no TRI_COUNT change.

Verification
REQ-033 Push one triangle 0x0040_0080_00C0_0040_0100_0040_F800_07E0_001F, FRAME_START 3 cycles later -> SD reproduces all 144 bits MSB-first in cycles t+1..t+144 with SD_VALID high; RAST_DONE 500 cycles later -> TRI_COUNT=1, BUSY=0.
REQ-034 With DEPTH=2, push 3 back-to-back triangles while idle without FRAME_START -> first two accepted, TRI_READY=0 on the third, FIFO_LEVEL=2 after pop-free cycles.
REQ-035 FRAME_START pulses during SHIFT and RAST_DONE during SHIFT -> no effect; serial stream and TRI_COUNT unchanged.
REQ-036 TIMEOUT=100, no RAST_DONE -> ERR=1 at WAIT_DONE cycle 100, TRI_COUNT unchanged, next queued triangle dispatched on next FRAME_START.
REQ-037 RST_N low at SHIFT bit 70 -> next cycle SD_VALID=0, FIFO_LEVEL=0, TRI_COUNT=0, ERR=0.
